// File: rtl/alu_bist.sv
// Built-in self-test sequencer for a 32-bit ALU: runs directed and LFSR
// vectors, compares result and zero flag, reports the first failure.
module alu_bist #(
    parameter int          N_RAND        = 16,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_idx,
    output logic [31:0] fail_got,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic [31:0] POLY      = 32'h8020_0003;
    localparam logic [7:0]  LAST_IDX  = 8'(9 + N_RAND);
    localparam logic [3:0]  WAIT_LAST = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] exp_q, exp_d;
    logic        pass_q, pass_d;
    logic [7:0]  fail_idx_q, fail_idx_d;
    logic [31:0] fail_got_q, fail_got_d;

    logic        start_ok;
    logic        mismatch;
    logic        last_vec;
    logic        is_rand;
    logic [31:0] fix_a, fix_b;
    logic [31:0] lfsr_1, lfsr_2;
    logic [31:0] vec_a, vec_b;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] golden(
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            4'd6:    r = a >> b[4:0];
            4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
            4'd8:    r = {31'd0, $signed(a) < $signed(b)};
            4'd9:    r = {31'd0, a < b};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    assign mismatch = (alu_result != exp_q) || (alu_zero != (exp_q == 32'd0));
    assign last_vec = (idx_q == LAST_IDX);
    assign is_rand  = (idx_q >= 8'd10);
    assign lfsr_1   = lfsr_step(lfsr_q);
    assign lfsr_2   = lfsr_step(lfsr_1);
    assign vec_a    = is_rand ? lfsr_1 : fix_a;
    assign vec_b    = is_rand ? lfsr_2 : fix_b;

    always_comb begin
        fix_a = 32'd0;
        fix_b = 32'd0;
        case (idx_q[3:0])
            4'd0: begin fix_a = 32'd5;        fix_b = 32'd3;        end
            4'd1: begin fix_a = 32'd5;        fix_b = 32'd5;        end
            4'd2,
            4'd3,
            4'd4: begin fix_a = 32'hFFFF0000; fix_b = 32'h00FF00FF; end
            4'd5: begin fix_a = 32'd1;        fix_b = 32'd8;        end
            4'd6: begin fix_a = 32'h000000F0; fix_b = 32'd4;        end
            4'd7: begin fix_a = 32'hFFFFFFF0; fix_b = 32'd4;        end
            4'd8: begin fix_a = 32'hFFFFFFFB; fix_b = 32'd3;        end
            4'd9: begin fix_a = 32'hFFFFFFFF; fix_b = 32'd1;        end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 8'd0;
            op_q       <= 4'd0;
            wait_q     <= 4'd0;
            lfsr_q     <= LFSR_SEED;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            ctrl_q     <= 4'd0;
            exp_q      <= 32'd0;
            pass_q     <= 1'b0;
            fail_idx_q <= 8'd0;
            fail_got_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            wait_q     <= wait_d;
            lfsr_q     <= lfsr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctrl_q     <= ctrl_d;
            exp_q      <= exp_d;
            pass_q     <= pass_d;
            fail_idx_q <= fail_idx_d;
            fail_got_q <= fail_got_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE,
            S_DONE:  if (start) state_d = S_DRIVE;
            S_DRIVE: state_d = S_WAIT;
            S_WAIT:  if (wait_q == WAIT_LAST) state_d = S_CHECK;
            S_CHECK: state_d = (mismatch || last_vec) ? S_DONE : S_DRIVE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        op_d       = op_q;
        wait_d     = wait_q;
        lfsr_d     = lfsr_q;
        a_d        = a_q;
        b_d        = b_q;
        ctrl_d     = ctrl_q;
        exp_d      = exp_q;
        pass_d     = pass_q;
        fail_idx_d = fail_idx_q;
        fail_got_d = fail_got_q;
        if (start_ok) begin
            idx_d      = 8'd0;
            op_d       = 4'd0;
            lfsr_d     = LFSR_SEED;
            pass_d     = 1'b0;
            fail_idx_d = 8'd0;
            fail_got_d = 32'd0;
        end
        unique case (state_q)
            S_DRIVE: begin
                a_d    = vec_a;
                b_d    = vec_b;
                ctrl_d = op_q;
                exp_d  = golden(op_q, vec_a, vec_b);
                wait_d = 4'd0;
                if (is_rand) lfsr_d = lfsr_2;
            end
            S_WAIT: wait_d = wait_q + 4'd1;
            S_CHECK: begin
                if (mismatch) begin
                    fail_idx_d = idx_q;
                    fail_got_d = alu_result;
                    pass_d     = 1'b0;
                end else if (last_vec) begin
                    pass_d = 1'b1;
                end else begin
                    idx_d = idx_q + 8'd1;
                    op_d  = (op_q == 4'd9) ? 4'd0 : op_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_DRIVE,
            S_WAIT,
            S_CHECK: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign pass     = pass_q;
    assign fail_idx = fail_idx_q;
    assign fail_got = fail_got_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = ctrl_q;

endmodule

// File: tb/tb_alu_bist.sv
// Randomized scoreboard bench for alu_bist with a bench-side ALU that can
// carry an injected fault.
module tb_alu_bist;

    localparam int          N_RAND = 16;
    localparam int          SETTLE = 2;
    localparam int          NVEC   = 10 + N_RAND;
    localparam int          VCYC   = 2 + SETTLE;
    localparam logic [31:0] SEED   = 32'hACE1_2468;

    localparam logic [31:0] FA [10] = '{
        32'd5, 32'd5, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
        32'd1, 32'hF0, 32'hFFFFFFF0, 32'hFFFFFFFB, 32'hFFFFFFFF};
    localparam logic [31:0] FB [10] = '{
        32'd3, 32'd5, 32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF,
        32'd8, 32'd4, 32'd4, 32'd3, 32'd1};

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } vec_t;

    typedef struct {
        logic        pass;
        logic [7:0]  idx;
        logic [31:0] got;
        int          cyc;
    } dexp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, pass;
    logic [7:0]  fail_idx;
    logic [31:0] fail_got, alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    int          mode;
    int          checks   = 0;
    int          failures = 0;

    vec_t  vec_q[$];
    dexp_t dexp_q[$];

    always #5 clk = ~clk;

    alu_bist #(
        .N_RAND(N_RAND),
        .SETTLE_CYCLES(SETTLE),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .pass(pass),
        .fail_idx(fail_idx),
        .fail_got(fail_got),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .alu_zero(alu_zero)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return $unsigned($signed(a) >>> sh);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // mode 1: SLTU result inverted, mode 2: zero flag stuck at 0
    function automatic logic [31:0] bad_res(input int m, input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        r = ref_alu(op, a, b);
        if (m == 1 && op == 4'd9) r = r ^ 32'd1;
        return r;
    endfunction

    function automatic logic bad_zero(input int m, input logic [31:0] r);
        return (m == 2) ? 1'b0 : (r == 32'd0);
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    assign alu_result = bad_res(mode, alu_ctrl, alu_a, alu_b);
    assign alu_zero   = bad_zero(mode, alu_result);

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] got);
        checks++;
        failures++;
        $display("FAIL %s got=%h", name, got);
    endtask

    task automatic build_run(input int m);
        logic [31:0] s, a, b, gold, r;
        logic [3:0]  op;
        vec_t        v;
        dexp_t       d;
        bit          failed;
        s      = SEED;
        failed = 0;
        for (int i = 0; i < NVEC; i++) begin
            if (i < 10) begin
                a = FA[i];
                b = FB[i];
            end else begin
                s = lfsr_next(s);
                a = s;
                s = lfsr_next(s);
                b = s;
            end
            op   = 4'(i % 10);
            v.a  = a;
            v.b  = b;
            v.op = op;
            vec_q.push_back(v);
            gold = ref_alu(op, a, b);
            r    = bad_res(m, op, a, b);
            if (r !== gold || bad_zero(m, r) !== (gold == 32'd0)) begin
                d.pass = 1'b0;
                d.idx  = 8'(i);
                d.got  = r;
                d.cyc  = (i + 1) * VCYC + 1;
                dexp_q.push_back(d);
                failed = 1;
                break;
            end
        end
        if (!failed) begin
            d.pass = 1'b1;
            d.idx  = 8'd0;
            d.got  = 32'd0;
            d.cyc  = NVEC * VCYC + 1;
            dexp_q.push_back(d);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_fail_idx"}, 32'(fail_idx), 32'd0);
        chk({tag, "_fail_got"}, fail_got, 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < NVEC * VCYC + 50; i++) begin
            @(negedge clk);
            if (done) return;
        end
        flag("wait_done", 32'(done));
    endtask

    task automatic run(input int m, input bit repulse);
        mode = m;
        build_run(m);
        pulse_start();
        if (repulse) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done();
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(done), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          pend, run_on;
        int          cyc, vk, busy_cnt;
        logic [67:0] last;
        vec_t        v;
        dexp_t       d;
        pend     = 0;
        run_on   = 0;
        cyc      = 0;
        vk       = 0;
        busy_cnt = 0;
        last     = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 0;
        fork
            begin
                repeat (3) @(negedge clk);
                chk_zero_outputs("reset");
                @(posedge clk);
                #1 rst_n = 1'b1;

                run(0, 0);
                run(0, 1);
                run(1, 0);
                run(2, 0);

                mode = 0;
                build_run(0);
                pulse_start();
                repeat (10) @(posedge clk);
                #3 rst_n = 1'b0;
                #1 chk_zero_outputs("abort");
                vec_q.delete();
                dexp_q.delete();
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (10) @(negedge clk);
                chk("post_abort_done", 32'(done), 32'd0);
                chk("post_abort_busy", 32'(busy), 32'd0);
                run(0, 0);

                for (int r = 0; r < 5; r++) begin
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                    run(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                end
                repeat (2) @(negedge clk);
            end
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    run_on = 0;
                    pend   = 0;
                end else begin
                    if (pend) begin
                        run_on   = 1;
                        cyc      = 0;
                        vk       = 0;
                        busy_cnt = 0;
                        last     = {alu_ctrl, alu_a, alu_b};
                    end
                    pend = start && !busy;
                    if (run_on) begin
                        cyc++;
                        if (busy) busy_cnt++;
                        if (busy && {alu_ctrl, alu_a, alu_b} != last) begin
                            last = {alu_ctrl, alu_a, alu_b};
                            if (vec_q.size() == 0) begin
                                flag("extra_vec", alu_a);
                            end else begin
                                v = vec_q.pop_front();
                                chk("vec_a", alu_a, v.a);
                                chk("vec_b", alu_b, v.b);
                                chk("vec_op", 32'(alu_ctrl), 32'(v.op));
                                chk("vec_cyc", cyc, vk * VCYC + 2);
                                vk++;
                            end
                        end
                        if (done) begin
                            run_on = 0;
                            chk("done_busy", 32'(busy), 32'd0);
                            if (dexp_q.size() == 0) begin
                                flag("extra_done", cyc);
                            end else begin
                                d = dexp_q.pop_front();
                                chk("done_cyc", cyc, d.cyc);
                                chk("pass", 32'(pass), 32'(d.pass));
                                chk("fail_idx", 32'(fail_idx), 32'(d.idx));
                                chk("fail_got", fail_got, d.got);
                                chk("busy_cycles", busy_cnt, d.cyc - 1);
                                chk("vec_left", vec_q.size(), 32'd0);
                            end
                        end else if (cyc > NVEC * VCYC + 20) begin
                            flag("done_timeout", cyc);
                            run_on = 0;
                        end
                    end
                end
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
